seq_det_prog: RTL and testbench

Programmable serial pattern detector: the next generation of the fixed 4-bit Moore sequence detector. Samples one bit per qualified clock, compares the most recent `pat_len` bits against a runtime-loaded pattern of up to `PAT_W` bits, and supports both overlapping and non-overlapping detection. Emits a registered one-cycle match pulse and keeps a saturating match count. It sits on the serial receive path between the bit slicer and the frame/status logic.

---
 rtl/seq_det_prog.sv | 131 +++++++++++++
 tb/tb_seq_det_prog.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: matches the last len accepted bits against a loaded
// pattern (overlapping or not). Match counter built only when SEQ_DET_PROG_COUNT_EN is defined.
module seq_det_prog #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 8'h0A,
  parameter int               DEF_LEN = 4,
  localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             seq_detected,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(DEF_LEN);
  localparam logic             RST_ERR = (DEF_LEN < 1) || (DEF_LEN > PAT_W);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             err_q, err_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             det_q, det_d;

  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill_inc;
  logic             hit;

  // Match is evaluated on the history including the bit being accepted this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    len_mask   = '0;
    hist_shift = {hist_q[PAT_W-2:0], data_in};
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    fill_inc = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
    hit = data_valid && !cfg_load && !err_q && (fill_inc == len_q) &&
          (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    err_d  = err_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    if (cfg_load) begin
      pat_d  = cfg_pat;
      len_d  = cfg_len;
      ovl_d  = cfg_ovl;
      err_d  = (cfg_len == '0) || (cfg_len > MAX_LEN);
      hist_d = '0;
      fill_d = '0;
    end else if (data_valid) begin
      hist_d = hist_shift;
      det_d  = hit;
      if (err_q || (hit && !ovl_q)) begin
        fill_d = '0;
      end else begin
        fill_d = fill_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments and async reset, including config registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= DEF_PAT;
      len_q  <= RST_LEN;
      ovl_q  <= 1'b1;
      err_q  <= RST_ERR;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      err_q  <= err_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  assign seq_detected = det_q;
  assign cfg_err      = err_q;

`ifdef SEQ_DET_PROG_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load || cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: directed vector table, async reset sequence and
// random stimulus against a bit-queue reference model. Count checks follow SEQ_DET_PROG_COUNT_EN.
module tb_seq_det_prog;

  logic       clk;
  logic       rst_n;
  logic       data_in;
  logic       data_valid;
  logic       cfg_load;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_ovl;
  logic       cnt_clr;
  logic       seq_detected, seq_detected2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic       cfg_err, cfg_err2;

  int errors = 0;
  int checks = 0;

  seq_det_prog u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .cnt_clr(cnt_clr), .seq_detected(seq_detected), .match_count(match_count),
    .cfg_err(cfg_err)
  );

  seq_det_prog #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .cnt_clr(cnt_clr), .seq_detected(seq_detected2), .match_count(match_count2),
    .cfg_err(cfg_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits accepted since the last fresh start, newest at the back.
  bit         m_bits[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl, m_err, m_det;
  int         m_cnt, m_cnt2;

  typedef struct {
    logic       v, d, ld;
    logic [7:0] p;
    logic [3:0] l;
    logic       o, c;
    logic       e_det;
    int         e_cnt;
    logic       e_err;
  } vec_t;
  vec_t vecs[$];

  function automatic int cnt_exp(input int n);
`ifdef SEQ_DET_PROG_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_bits.delete();
    m_pat  = 8'h0A;
    m_len  = 4;
    m_ovl  = 1'b1;
    m_err  = 1'b0;
    m_det  = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  task automatic model_update(input logic v, d, ld, input logic [7:0] p, input logic [3:0] l,
                              input logic o, c);
    bit match;
    m_det = 1'b0;
    if (ld) begin
      m_pat = p;
      m_len = int'(l);
      m_ovl = o;
      m_err = (l == 0) || (l > 8);
      m_bits.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
    end else begin
      if (v && !m_err) begin
        m_bits.push_back(d);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        match = (m_bits.size() >= m_len);
        for (int k = 0; k < m_len && match; k++) begin
          if (m_bits[m_bits.size() - m_len + k] != m_pat[m_len - 1 - k]) match = 1'b0;
        end
        if (match) begin
          m_det = 1'b1;
          if (!m_ovl) m_bits.delete();
        end
      end
      if (c) begin
        m_cnt  = 0;
        m_cnt2 = 0;
      end else if (m_det) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input logic v, d, ld, input logic [7:0] p, input logic [3:0] l,
                      input logic o, c);
    data_valid = v;
    data_in    = d;
    cfg_load   = ld;
    cfg_pat    = p;
    cfg_len    = l;
    cfg_ovl    = o;
    cnt_clr    = c;
    @(posedge clk);
    model_update(v, d, ld, p, l, o, c);
    #1;
    check("model det", 32'(seq_detected), 32'(m_det));
    check("model err", 32'(cfg_err), 32'(m_err));
    check("model cnt", 32'(match_count), 32'(cnt_exp(m_cnt)));
    check("model cnt2", 32'(match_count2), 32'(cnt_exp(m_cnt2)));
  endtask

  task automatic add(input logic v, d, ld, input logic [7:0] p, input logic [3:0] l,
                     input logic o, c, input logic e_det, input int e_cnt, input logic e_err);
    vec_t t;
    t.v = v; t.d = d; t.ld = ld; t.p = p; t.l = l; t.o = o; t.c = c;
    t.e_det = e_det; t.e_cnt = e_cnt; t.e_err = e_err;
    vecs.push_back(t);
  endtask

  task automatic bit_in(input logic d, input logic e_det, input int e_cnt, input logic e_err);
    add(1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, e_det, e_cnt, e_err);
  endtask

  task automatic idle(input int e_cnt, input logic e_err);
    add(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, e_cnt, e_err);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic e_err);
    add(1'b0, 1'b0, 1'b1, p, l, o, 1'b0, 1'b0, 0, e_err);
  endtask

  initial begin
    logic       rv, rd, rld, ro, rc;
    logic [7:0] rp;
    logic [3:0] rl;

    rst_n = 1'b0; data_in = 1'b0; data_valid = 1'b0; cfg_load = 1'b0;
    cfg_pat = 8'h00; cfg_len = 4'd0; cfg_ovl = 1'b0; cnt_clr = 1'b0;
    m_reset();
    #12;
    check("reset det", 32'(seq_detected), 32'd0);
    check("reset cnt", 32'(match_count), 32'd0);
    check("reset err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults (1010, len 4, overlapping)
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 0);
    idle(1, 0);
    // 101 overlapping, then non-overlapping
    load(8'h05, 4'd3, 1'b1, 1'b0);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 1, 0); bit_in(0, 0, 1, 0); bit_in(1, 1, 2, 0);
    load(8'h05, 4'd3, 1'b0, 1'b0);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 1, 0); bit_in(0, 0, 1, 0); bit_in(1, 0, 1, 0);
    // 1010 with two idle cycles between valid bits
    load(8'h0A, 4'd4, 1'b1, 1'b0);
    bit_in(1, 0, 0, 0); idle(0, 0); idle(0, 0);
    bit_in(0, 0, 0, 0); idle(0, 0); idle(0, 0);
    bit_in(1, 0, 0, 0); idle(0, 0); idle(0, 0);
    bit_in(0, 1, 1, 0); idle(1, 0); idle(1, 0);
    // Invalid length disables detection
    load(8'h0A, 4'd0, 1'b1, 1'b1);
    bit_in(1, 0, 0, 1); bit_in(0, 0, 0, 1); bit_in(1, 0, 0, 1); bit_in(0, 0, 0, 1);
    load(8'hFF, 4'd9, 1'b1, 1'b1);
    bit_in(1, 0, 0, 1); bit_in(1, 0, 0, 1);
    // Load coincident with a valid bit: the bit is discarded
    add(1'b1, 1'b1, 1'b1, 8'h05, 4'd3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 1, 0);
    // Clear coincident with a match: pulse kept, count cleared
    bit_in(0, 0, 1, 0);
    add(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    // Five matches on pattern 11 for the 2-bit counter
    load(8'h03, 4'd2, 1'b1, 1'b0);
    bit_in(1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) bit_in(1, 1, i, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].ld, vecs[i].p, vecs[i].l, vecs[i].o, vecs[i].c);
      check($sformatf("vec%0d det", i), 32'(seq_detected), 32'(vecs[i].e_det));
      check($sformatf("vec%0d cnt", i), 32'(match_count), 32'(cnt_exp(vecs[i].e_cnt)));
      check($sformatf("vec%0d err", i), 32'(cfg_err), 32'(vecs[i].e_err));
    end
    check("cnt2 saturated", 32'(match_count2), 32'(cnt_exp(3)));

    // Async reset with the pulse high and a non-zero count
    step(0, 0, 1, 8'h0A, 4'd4, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0);
    check("pre-reset det", 32'(seq_detected), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async det", 32'(seq_detected), 32'd0);
    check("async cnt", 32'(match_count), 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0);
    check("post-reset 010", 32'(seq_detected), 32'd0);
    step(1, 1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0);
    check("post-reset 1010", 32'(seq_detected), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rd  = 1'($urandom_range(0, 1));
      rld = ($urandom_range(0, 99) < 3);
      rp  = 8'($urandom);
      rl  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      ro  = 1'($urandom_range(0, 1));
      rc  = ($urandom_range(0, 49) == 0);
      step(rv, rd, rld, rp, rl, ro, rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
